// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline stage with two-entry skid buffer
// Optional saturating stall counter enabled by `define STAGE_STALL_CNT_EN.
module pipe_stage_elastic #(
  parameter int                WIDTH  = 64,
  parameter logic [WIDTH-1:0]  BUBBLE = '0,
  parameter int                CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             mainValid;
  logic             skidValid;
  logic [WIDTH-1:0] mainData;
  logic [WIDTH-1:0] skidData;
  logic             push;
  logic             pop;

  // skidValid implies mainValid, so the pair encodes EMPTY/ONE/FULL directly.
  assign occupancy = skidValid ? 2'd2 : (mainValid ? 2'd1 : 2'd0);
  assign in_ready  = !skidValid;
  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign push      = in_valid && !skidValid;
  assign pop       = mainValid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainData  <= BUBBLE;
      skidData  <= BUBBLE;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainData  <= BUBBLE;
      skidData  <= BUBBLE;
    end else if (!mainValid) begin
      if (push) begin
        mainValid <= 1'b1;
        mainData  <= in_data;
      end
    end else if (!skidValid) begin
      if (push && pop) begin
        mainData <= in_data;
      end else if (push) begin
        skidValid <= 1'b1;
        skidData  <= in_data;
      end else if (pop) begin
        mainValid <= 1'b0;
      end
    end else if (pop) begin
      mainData  <= skidData;
      skidValid <= 1'b0;
    end
  end

`ifdef STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  // Saturates rather than wraps; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (mainValid && !out_ready && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign stall_cnt = stallCnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
